datapath_control_unit: RTL and testbench
========================================

Name: datapath_control_unit

Overview:
- Hardwired Moore sequencer that drives the datapath's register enables, bus source select, ALU opcode and GP write address.
- Fetches an instruction from memory, decodes the IR opcode, and steps the instruction's execute T-states.
- Sits between the datapath and the memory interface and handshakes memory reads through mem_req/mem_ready.
- Supports add, sub, and, or, addi, andi, ori, ldi, ld, mul, div and halt.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- ALU_ADD, 4'b0001, ALU code for add/addi/ldi/ld address.
- ALU_SUB, 4'b0010, ALU code for sub.
- ALU_AND, 4'b0011, ALU code for and/andi.
- ALU_OR, 4'b0100, ALU code for or/ori.
- ALU_MUL, 4'b0101, ALU code for mul.
- ALU_DIV, 4'b0110, ALU code for div.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  leave IDLE and start fetching.
- IR  in  32  datapath IR contents: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- mem_req  out  1  memory read request.
- MDR_read  out  1  MDR input mux selects Mdatain.
- incPC  out  1  PC increment.
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  out  1 each  register load enables.
- GP_addr  out  4  GP write address.
- BusDataSelect  out  5  bus source select:
  - 0-15 = R0-R15
  - 16 = HI, 17 = LO
  - 18 = Zhigh, 19 = Zlow
  - 20 = PC, 21 = MDR
  - 23 = sign-extended C
- ALU_op  out  4  ALU operation.
- halted  out  1  HALT state reached.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Outputs are combinational from the state and IR. Every output not listed for a state is 0.
- Reset (clear=0): state goes to IDLE immediately; retired=0, halted=0. All outputs read 0 at once, including mem_req mid-wait.
- IDLE: go to T0 when run=1.

Fetch:
- T0: BusDataSelect=20, e_MAR=1, incPC=1.
- T1: mem_req=1, MDR_read=1. Hold in T1 until mem_ready=1; e_MDR=mem_ready. Exit T1 on the edge where mem_ready=1. There is no timeout.
- T2: BusDataSelect=21, e_IR=1. The IR input is valid from T3 onward.

Opcodes:
- add 00011, sub 00100, and 00101, or 00110
- addi 01100, andi 01101, ori 01110
- ldi 00001, ld 00000
- div 01111, mul 10000, halt 11011

R-type (add/sub/and/or):
- T3: sel=Rb, e_Y.
- T4: sel=Rc, ALU_op per opcode, e_Z.
- T5: sel=19, e_GP, GP_addr=Ra. Then retire and go to T0.

Immediate (addi/andi/ori/ldi):
- Same as R-type, but T4 uses sel=23.
- ldi uses ALU_ADD.

ld:
- T3, T4 as ldi (ALU_ADD).
- T5: sel=19, e_MAR.
- T6: memory wait, identical rules to T1.
- T7: sel=21, e_GP, GP_addr=Ra. Then retire and go to T0.

mul/div:
- T3: sel=Ra, e_Y.
- T4: sel=Rb, ALU_op, e_Z.
- T5: sel=19, e_LO.
- T6: sel=18, e_HI. Then retire and go to T0.

halt:
- T3 goes to HALT; halted=1; retired increments once.
- HALT is left only by reset. run is ignored.

Unsupported opcode:
- T3: illegal=1 for that cycle. Go to T0; retired is unchanged.

Retired counter and run:
- "Retire" means retired+1 on the final-state edge. It wraps modulo 2^CNT_W.
- run is only sampled in IDLE. Dropping run mid-program does not stop execution.

Test Plan:
- Reset then run=1 with mem_ready tied 1, memory[0]=add R3,R1,R2 (R1=5, R2=7) -> R3=12 after T5; retired=1; state returns to T0.
- Fetch with mem_ready delayed 3 cycles -> mem_req and MDR_read held 4 cycles, e_MDR only in the ready cycle, IR loaded next cycle.
- addi R4,R1,-3 (C=19'h7FFFD), R1=5 -> T4 sel=23, R4=2; ld R5,4(R1) with mem[9]=CAFEBABE -> R5=CAFEBABE.
- mul R1,R2 with R1=0x10000, R2=0x10000 -> LO=0, HI=1, e_LO in T5, e_HI in T6, no e_GP.
- Opcode 11111 -> illegal pulse 1 cycle in T3, retired unchanged; halt -> halted=1, run toggling has no effect, retired+1.
- clear=0 asserted while in T1 with mem_req=1 -> mem_req=0 and all enables 0 without a clock edge; after release, remains IDLE until run.

Source files
------------

// File: rtl/datapath_control_unit.sv
// Hardwired Moore sequencer: fetch (T0-T2), decode and execute (T3-T7), HALT.
// Outputs decode combinationally from state and IR; memory reads stall in T1/T6 until mem_ready.
module datapath_control_unit #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] ALU_ADD = 4'b0001,
  parameter logic [3:0] ALU_SUB = 4'b0010,
  parameter logic [3:0] ALU_AND = 4'b0011,
  parameter logic [3:0] ALU_OR  = 4'b0100,
  parameter logic [3:0] ALU_MUL = 4'b0101,
  parameter logic [3:0] ALU_DIV = 4'b0110
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MDR_read,
  output logic             incPC,
  output logic             e_PC,
  output logic             e_IR,
  output logic             e_Y,
  output logic             e_Z,
  output logic             e_HI,
  output logic             e_LO,
  output logic             e_MDR,
  output logic             e_MAR,
  output logic             e_GP,
  output logic [3:0]       GP_addr,
  output logic [4:0]       BusDataSelect,
  output logic [3:0]       ALU_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_r, is_i, is_ld, is_md, is_halt, known;
  logic [3:0] alu_code;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_ld    = 1'b0;
    is_md    = 1'b0;
    is_halt  = 1'b0;
    alu_code = 4'b0000;
    case (opcode)
      OP_ADD:  begin is_r = 1'b1;  alu_code = ALU_ADD; end
      OP_SUB:  begin is_r = 1'b1;  alu_code = ALU_SUB; end
      OP_AND:  begin is_r = 1'b1;  alu_code = ALU_AND; end
      OP_OR:   begin is_r = 1'b1;  alu_code = ALU_OR;  end
      OP_ADDI: begin is_i = 1'b1;  alu_code = ALU_ADD; end
      OP_ANDI: begin is_i = 1'b1;  alu_code = ALU_AND; end
      OP_ORI:  begin is_i = 1'b1;  alu_code = ALU_OR;  end
      OP_LDI:  begin is_i = 1'b1;  alu_code = ALU_ADD; end
      OP_LD:   begin is_ld = 1'b1; alu_code = ALU_ADD; end
      OP_MUL:  begin is_md = 1'b1; alu_code = ALU_MUL; end
      OP_DIV:  begin is_md = 1'b1; alu_code = ALU_DIV; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    known = is_r | is_i | is_ld | is_md | is_halt;
  end

  // Retirement happens on the edge leaving each instruction's final state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      retired <= '0;
    end else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0:   state <= T1;
        T1:   if (mem_ready) state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_halt) begin
            state   <= HALT;
            retired <= retired + 1'b1;
          end else if (!known) begin
            state <= T0;
          end else begin
            state <= T4;
          end
        end
        T4:   state <= T5;
        T5: begin
          if (is_r || is_i) begin
            state   <= T0;
            retired <= retired + 1'b1;
          end else begin
            state <= T6;
          end
        end
        T6: begin
          if (is_ld) begin
            if (mem_ready) state <= T7;
          end else begin
            state   <= T0;
            retired <= retired + 1'b1;
          end
        end
        T7: begin
          state   <= T0;
          retired <= retired + 1'b1;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    MDR_read      = 1'b0;
    incPC         = 1'b0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    GP_addr       = 4'd0;
    BusDataSelect = 5'd0;
    ALU_op        = 4'd0;
    illegal       = 1'b0;
    halted        = (state == HALT);
    case (state)
      T0: begin
        BusDataSelect = 5'd20;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
      end
      T1: begin
        mem_req  = 1'b1;
        MDR_read = 1'b1;
        e_MDR    = mem_ready;
      end
      T2: begin
        BusDataSelect = 5'd21;
        e_IR          = 1'b1;
      end
      T3: begin
        if (is_md) begin
          BusDataSelect = {1'b0, ra};
          e_Y           = 1'b1;
        end else if (is_r || is_i || is_ld) begin
          BusDataSelect = {1'b0, rb};
          e_Y           = 1'b1;
        end
        illegal = ~known;
      end
      T4: begin
        if (is_md)     BusDataSelect = {1'b0, rb};
        else if (is_r) BusDataSelect = {1'b0, rc};
        else           BusDataSelect = 5'd23;
        ALU_op = alu_code;
        e_Z    = 1'b1;
      end
      T5: begin
        BusDataSelect = 5'd19;
        if (is_ld)      e_MAR = 1'b1;
        else if (is_md) e_LO  = 1'b1;
        else begin
          e_GP    = 1'b1;
          GP_addr = ra;
        end
      end
      T6: begin
        if (is_ld) begin
          mem_req  = 1'b1;
          MDR_read = 1'b1;
          e_MDR    = mem_ready;
        end else begin
          BusDataSelect = 5'd18;
          e_HI          = 1'b1;
        end
      end
      T7: begin
        BusDataSelect = 5'd21;
        e_GP          = 1'b1;
        GP_addr       = ra;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: walks fetch/execute sequences and checks control outputs.
module tb_datapath_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic        mem_req, MDR_read, incPC;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic [3:0]  GP_addr;
  logic [4:0]  BusDataSelect;
  logic [3:0]  ALU_op;
  logic        halted, illegal;
  logic [15:0] retired;

  int total = 0;
  int passed = 0;

  datapath_control_unit dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
    .mem_req(mem_req), .MDR_read(MDR_read), .incPC(incPC), .e_PC(e_PC),
    .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .GP_addr(GP_addr),
    .BusDataSelect(BusDataSelect), .ALU_op(ALU_op), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Runs T0->T1->T2 with memory ready, loads instr into IR during T2, ends in T3.
  task automatic fetch(input logic [31:0] instr);
    mem_ready = 1'b1;
    chk("fetch_t0_sel", {27'd0, BusDataSelect}, 32'd20);
    tick();
    chk("fetch_t1_req", {31'd0, mem_req}, 32'd1);
    tick();
    chk("fetch_t2_eir", {31'd0, e_IR}, 32'd1);
    IR = instr;
    tick();
  endtask

  initial begin
    int req_cycles;
    clear = 1'b0; run = 1'b0; IR = '0; mem_ready = 1'b0;
    #3;
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    #4 clear = 1'b1;
    tick();
    chk("idle_no_run", {31'd0, e_MAR}, 32'd0);

    // add R3,R1,R2 with memory always ready
    run = 1'b1; mem_ready = 1'b1;
    tick();
    chk("t0_sel", {27'd0, BusDataSelect}, 32'd20);
    chk("t0_mar", {30'd0, e_MAR, incPC}, 32'd3);
    tick();
    chk("t1_req", {29'd0, mem_req, MDR_read, e_MDR}, 32'd7);
    tick();
    chk("t2_sel", {27'd0, BusDataSelect}, 32'd21);
    chk("t2_eir", {31'd0, e_IR}, 32'd1);
    IR = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    tick();
    chk("add_t3_sel", {27'd0, BusDataSelect}, 32'd1);
    chk("add_t3_ey", {31'd0, e_Y}, 32'd1);
    tick();
    chk("add_t4_sel", {27'd0, BusDataSelect}, 32'd2);
    chk("add_t4_alu", {27'd0, e_Z, ALU_op}, 32'h11);
    tick();
    chk("add_t5_sel", {27'd0, BusDataSelect}, 32'd19);
    chk("add_t5_gp", {27'd0, e_GP, GP_addr}, 32'h13);
    chk("add_t5_ret", {16'd0, retired}, 32'd0);
    run = 1'b0;
    tick();
    chk("add_ret", {16'd0, retired}, 32'd1);
    chk("add_back_t0", {27'd0, BusDataSelect}, 32'd20);

    // fetch with memory ready delayed three cycles
    mem_ready = 1'b0;
    req_cycles = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (mem_req && MDR_read) req_cycles++;
      chk("wait_emdr", {31'd0, e_MDR}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("wait_req_cycles", req_cycles, 32'd4);
    chk("wait_t2_eir", {31'd0, e_IR}, 32'd1);
    chk("wait_t2_req", {31'd0, mem_req}, 32'd0);

    // addi R4,R1,-3
    IR = {5'b01100, 4'd4, 4'd1, 19'h7FFFD};
    tick();
    chk("addi_t3_sel", {27'd0, BusDataSelect}, 32'd1);
    tick();
    chk("addi_t4_sel", {27'd0, BusDataSelect}, 32'd23);
    chk("addi_t4_alu", {28'd0, ALU_op}, 32'd1);
    tick();
    chk("addi_t5_gp", {27'd0, e_GP, GP_addr}, 32'h14);
    tick();
    chk("addi_ret", {16'd0, retired}, 32'd2);

    // ld R5,4(R1) with a one-cycle memory stall in T6
    fetch({5'b00000, 4'd5, 4'd1, 19'd4});
    chk("ld_t3_sel", {27'd0, BusDataSelect}, 32'd1);
    tick();
    chk("ld_t4_sel", {27'd0, BusDataSelect}, 32'd23);
    chk("ld_t4_alu", {28'd0, ALU_op}, 32'd1);
    tick();
    chk("ld_t5_mar", {30'd0, e_MAR, e_GP}, 32'd2);
    chk("ld_t5_sel", {27'd0, BusDataSelect}, 32'd19);
    mem_ready = 1'b0;
    tick();
    chk("ld_t6_wait", {29'd0, mem_req, MDR_read, e_MDR}, 32'd6);
    tick();
    chk("ld_t6_hold", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("ld_t6_ready", {31'd0, e_MDR}, 32'd1);
    tick();
    chk("ld_t7_sel", {27'd0, BusDataSelect}, 32'd21);
    chk("ld_t7_gp", {27'd0, e_GP, GP_addr}, 32'h15);
    tick();
    chk("ld_ret", {16'd0, retired}, 32'd3);

    // mul R1,R2
    fetch({5'b10000, 4'd1, 4'd2, 19'd0});
    chk("mul_t3_sel", {27'd0, BusDataSelect}, 32'd1);
    tick();
    chk("mul_t4_sel", {27'd0, BusDataSelect}, 32'd2);
    chk("mul_t4_alu", {28'd0, ALU_op}, 32'd5);
    tick();
    chk("mul_t5", {27'd0, BusDataSelect}, 32'd19);
    chk("mul_t5_en", {29'd0, e_LO, e_HI, e_GP}, 32'd4);
    tick();
    chk("mul_t6", {27'd0, BusDataSelect}, 32'd18);
    chk("mul_t6_en", {29'd0, e_LO, e_HI, e_GP}, 32'd2);
    tick();
    chk("mul_ret", {16'd0, retired}, 32'd4);

    // div R6,R7
    fetch({5'b01111, 4'd6, 4'd7, 19'd0});
    chk("div_t3_sel", {27'd0, BusDataSelect}, 32'd6);
    tick();
    chk("div_t4_alu", {28'd0, ALU_op}, 32'd6);
    tick(); tick(); tick();
    chk("div_ret", {16'd0, retired}, 32'd5);

    // unsupported opcode 11111
    fetch({5'b11111, 27'd0});
    chk("ill_t3", {31'd0, illegal}, 32'd1);
    tick();
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    chk("ill_ret", {16'd0, retired}, 32'd5);
    chk("ill_back_t0", {27'd0, BusDataSelect}, 32'd20);

    // halt, then toggle run
    fetch({5'b11011, 27'd0});
    chk("halt_t3", {31'd0, halted}, 32'd0);
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_ret", {16'd0, retired}, 32'd6);
    run = 1'b1; tick(); run = 1'b0; tick(); run = 1'b1; tick();
    chk("halt_stays", {31'd0, halted}, 32'd1);
    chk("halt_ret_hold", {16'd0, retired}, 32'd6);
    chk("halt_no_fetch", {31'd0, e_MAR}, 32'd0);

    // reset out of HALT, then reset during a T1 memory wait
    clear = 1'b0;
    #1;
    chk("clr_halted", {31'd0, halted}, 32'd0);
    chk("clr_ret", {16'd0, retired}, 32'd0);
    #1 clear = 1'b1;
    run = 1'b1; mem_ready = 1'b0;
    tick();
    run = 1'b0;
    tick();
    chk("t1_wait_req", {31'd0, mem_req}, 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("async_req", {30'd0, mem_req, MDR_read}, 32'd0);
    chk("async_en", {23'd0, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP}, 32'd0);
    #1 clear = 1'b1;
    tick(); tick();
    chk("post_clr_idle", {30'd0, mem_req, e_MAR}, 32'd0);
    run = 1'b1;
    tick();
    chk("post_clr_run", {31'd0, e_MAR}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
